// File: rtl/demux_route.sv
// demux_route: registered 1-to-2 demultiplexer with per-port one-entry
// holding registers, valid/ready handshakes and saturating debug counters.

// One output port: holding register (data/tag/valid) plus transfer counter.
module demux_route_port #(
    parameter int DW = 32,
    parameter int TW = 5,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,    // input handshake targeting this port
    input  logic [DW-1:0] i_data,
    input  logic [TW-1:0] i_tag,
    input  logic          i_ready,   // consumer ready
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic [TW-1:0] o_tag,
    output logic [CW-1:0] o_count,
    output logic          o_free     // port can take a word this cycle
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [DW-1:0] r_data;
    logic [TW-1:0] r_tag;
    logic [CW-1:0] r_count;
    logic          w_drain;
    logic          w_load_en;
    logic          w_cnt_en;

    assign w_drain = (r_state == FULL) && i_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= EMPTY;
        else       r_state <= w_next;
    end

    // Next-state: fill from EMPTY, drain to EMPTY unless refilled same cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            EMPTY: if (i_load) w_next = FULL;
            FULL:  if (w_drain && !i_load) w_next = EMPTY;
        endcase
    end

    // Outputs: load strobe only when the slot is free, counter stops at all-ones
    always_comb begin
        w_load_en = i_load && ((r_state == EMPTY) || w_drain);
        w_cnt_en  = w_drain && (r_count != {CW{1'b1}});
        o_valid   = (r_state == FULL);
        o_free    = (r_state == EMPTY) || i_ready;
    end

    // Holding register: data and tag only change on an accepted word
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
            r_tag  <= '0;
        end else if (w_load_en) begin
            r_data <= i_data;
            r_tag  <= i_tag;
        end
    end

    // Saturating count of completed output handshakes
    always_ff @(posedge clk) begin
        if (reset)         r_count <= '0;
        else if (w_cnt_en) r_count <= r_count + 1'b1;
    end

    assign o_data  = r_data;
    assign o_tag   = r_tag;
    assign o_count = r_count;

endmodule

// Top: steers each accepted word to the port chosen by in_sel.
module demux_route #(
    parameter int DW = 32,
    parameter int TW = 5,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] in_data,
    input  logic [TW-1:0] in_tag,
    input  logic          in_sel,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out0_data,
    output logic [DW-1:0] out1_data,
    output logic [TW-1:0] out0_tag,
    output logic [TW-1:0] out1_tag,
    output logic          out0_valid,
    output logic          out1_valid,
    input  logic          out0_ready,
    input  logic          out1_ready,
    output logic [CW-1:0] out0_count,
    output logic [CW-1:0] out1_count
);

    localparam int NP = 2;

    logic [NP-1:0]         w_free;
    logic [NP-1:0]         w_load;
    logic [NP-1:0]         w_out_ready;
    logic [NP-1:0]         w_valid;
    logic [NP-1:0][DW-1:0] w_data;
    logic [NP-1:0][TW-1:0] w_tag;
    logic [NP-1:0][CW-1:0] w_count;
    logic                  w_in_hs;

    assign w_out_ready = {out1_ready, out0_ready};

    // Readiness depends only on the selected port, never the other one
    assign in_ready = !reset && w_free[in_sel];
    assign w_in_hs  = in_valid && in_ready;

    for (genvar g = 0; g < NP; g++) begin : g_port
        assign w_load[g] = w_in_hs && (in_sel == 1'(g));

        demux_route_port #(.DW(DW), .TW(TW), .CW(CW)) u_port (
            .clk     (clk),
            .reset   (reset),
            .i_load  (w_load[g]),
            .i_data  (in_data),
            .i_tag   (in_tag),
            .i_ready (w_out_ready[g]),
            .o_valid (w_valid[g]),
            .o_data  (w_data[g]),
            .o_tag   (w_tag[g]),
            .o_count (w_count[g]),
            .o_free  (w_free[g])
        );
    end

    assign out0_valid = w_valid[0];
    assign out1_valid = w_valid[1];
    assign out0_data  = w_data[0];
    assign out1_data  = w_data[1];
    assign out0_tag   = w_tag[0];
    assign out1_tag   = w_tag[1];
    assign out0_count = w_count[0];
    assign out1_count = w_count[1];

endmodule

// File: tb/tb_demux_route.sv
// Scoreboard bench for demux_route: directed stimulus pushes expected words
// per port, a negedge monitor pops and compares on every output handshake.
module tb_demux_route;

    localparam int DW = 32;
    localparam int TW = 5;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data;
    logic [TW-1:0] in_tag;
    logic          in_sel;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out0_data, out1_data;
    logic [TW-1:0] out0_tag, out1_tag;
    logic          out0_valid, out1_valid;
    logic          out0_ready, out1_ready;
    logic [CW-1:0] out0_count, out1_count;

    demux_route #(.DW(DW), .TW(TW), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_tag     (in_tag),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out1_data  (out1_data),
        .out0_tag   (out0_tag),
        .out1_tag   (out1_tag),
        .out0_valid (out0_valid),
        .out1_valid (out1_valid),
        .out0_ready (out0_ready),
        .out1_ready (out1_ready),
        .out0_count (out0_count),
        .out1_count (out1_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW+TW-1:0] q0[$];
    logic [DW+TW-1:0] q1[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake completes at the next posedge when valid&&ready now
    always @(negedge clk) begin
        logic [DW+TW-1:0] e;
        if (!reset) begin
            if (out0_valid && out0_ready) begin
                if (q0.size() == 0) chk("p0_unexpected", 64'(out0_data), 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    e = q0.pop_front();
                    chk("p0_data", 64'(out0_data), 64'(e[DW+TW-1:TW]));
                    chk("p0_tag",  64'(out0_tag),  64'(e[TW-1:0]));
                end
            end
            if (out1_valid && out1_ready) begin
                if (q1.size() == 0) chk("p1_unexpected", 64'(out1_data), 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    e = q1.pop_front();
                    chk("p1_data", 64'(out1_data), 64'(e[DW+TW-1:TW]));
                    chk("p1_tag",  64'(out1_tag),  64'(e[TW-1:0]));
                end
            end
        end
    end

    // Offer a word; push its expectation when it is accepted. Returns at posedge+1.
    task automatic send(input logic sel, input logic [DW-1:0] d, input logic [TW-1:0] t);
        bit ok = 0;
        in_sel = sel; in_data = d; in_tag = t; in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                if (sel) q1.push_back({d, t}); else q0.push_back({d, t});
                break;
            end
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int c0;
        reset = 1'b1; in_valid = 1'b1; in_sel = 1'b0;
        in_data = 32'h1234_5678; in_tag = 5'd9;
        out0_ready = 1'b0; out1_ready = 1'b0;

        // Reset held 2 cycles with in_valid=1
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("rst_in_ready2", 64'(in_ready), 64'd0);
        chk("rst_valids", 64'({out0_valid, out1_valid}), 64'd0);
        chk("rst_data", 64'({out0_data, out1_data}), 64'd0);
        chk("rst_tags", 64'({out0_tag, out1_tag}), 64'd0);
        chk("rst_counts", 64'({out0_count, out1_count}), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Single transfer to port 0, stalled, then drained
        send(1'b0, 32'hDEADBEEF, 5'd17);
        @(negedge clk);
        chk("st_valid0", 64'(out0_valid), 64'd1);
        chk("st_data0", 64'(out0_data), 64'hDEADBEEF);
        chk("st_tag0", 64'(out0_tag), 64'd17);
        chk("st_ready_sel0", 64'(in_ready), 64'd0);
        chk("st_valid1", 64'(out1_valid), 64'd0);
        in_sel = 1'b1; #1;
        chk("st_ready_sel1", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        chk("st_hold_data0", 64'(out0_data), 64'hDEADBEEF);
        out0_ready = 1'b1;
        step(1);
        chk("st_drain_valid0", 64'(out0_valid), 64'd0);
        chk("st_count0", 64'(out0_count), 64'd1);
        chk("st_keep_data0", 64'(out0_data), 64'hDEADBEEF);
        out0_ready = 1'b0;

        // Streaming 8 words to port 1, one per cycle
        out1_ready = 1'b1;
        c0 = cyc;
        for (int i = 1; i <= 8; i++) send(1'b1, 32'(i), 5'(i + 3));
        chk("stream_cycles", 64'(cyc - c0), 64'd8);
        step(2);
        chk("stream_count1", 64'(out1_count), 64'd8);
        chk("stream_valid1", 64'(out1_valid), 64'd0);
        chk("stream_p0_valid", 64'(out0_valid), 64'd0);
        chk("stream_p0_count", 64'(out0_count), 64'd1);
        chk("stream_p0_data", 64'(out0_data), 64'hDEADBEEF);
        out1_ready = 1'b0;

        // Simultaneous drain and fill on port 0
        send(1'b0, 32'hA, 5'd1);
        out0_ready = 1'b1;
        send(1'b0, 32'hB, 5'd2);
        out0_ready = 1'b0;
        @(negedge clk);
        chk("df_valid0", 64'(out0_valid), 64'd1);
        chk("df_data0", 64'(out0_data), 64'hB);
        chk("df_tag0", 64'(out0_tag), 64'd2);
        chk("df_count0", 64'(out0_count), 64'd2);
        @(posedge clk); #1;

        // Both ports full and stalled, then a 1-cycle reset
        send(1'b1, 32'hC, 5'd3);
        @(negedge clk);
        chk("ms_both_full", 64'({out0_valid, out1_valid}), 64'd3);
        in_sel = 1'b0; #1;
        chk("ms_bp_sel0", 64'(in_ready), 64'd0);
        in_sel = 1'b1; #1;
        chk("ms_bp_sel1", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        q0.delete(); q1.delete();
        chk("ms_valids", 64'({out0_valid, out1_valid}), 64'd0);
        chk("ms_counts", 64'({out0_count, out1_count}), 64'd0);
        out0_ready = 1'b1; out1_ready = 1'b1;
        step(3);
        chk("ms_no_deliver", 64'({out0_count, out1_count}), 64'd0);
        out0_ready = 1'b0;

        // Saturation: 300 handshakes on port 1
        for (int i = 0; i < 300; i++) send(1'b1, 32'(i * 7 + 1), 5'(i));
        step(2);
        chk("sat_count1", 64'(out1_count), 64'd255);
        for (int i = 0; i < 5; i++) send(1'b1, 32'hF00 + 32'(i), 5'(i));
        step(2);
        chk("sat_hold1", 64'(out1_count), 64'd255);
        chk("sat_p0_count", 64'(out0_count), 64'd0);
        out1_ready = 1'b0;

        step(2);
        chk("q0_empty", 64'(q0.size()), 64'd0);
        chk("q1_empty", 64'(q1.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
